// File: rtl/boot_pkg.sv
// Shared types and defaults for the boot copy sequencer.
package boot_pkg;

  localparam int unsigned OPCODE_W          = 4;
  localparam int unsigned DEFAULT_IMAGE_LEN = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_VREAD,
    S_DONE,
    S_ERROR
  } boot_state_t;

endpackage

// File: rtl/boot_copy_ctrl.sv
// Boot copy sequencer: copies the bootloader ROM image into IRAM, then releases the CPU.
// Optional IRAM readback verify is built when BOOT_VERIFY_EN is defined.
module boot_copy_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned ROM_ADDR_W = 4,
  parameter int unsigned DATA_W     = OPCODE_W,
  parameter int unsigned RAM_ADDR_W = 8,
  parameter int unsigned IMAGE_LEN  = DEFAULT_IMAGE_LEN,
  parameter int unsigned LOAD_BASE  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  output logic [ROM_ADDR_W-1:0] RomAddress,
  input  logic [DATA_W-1:0]     RomData,
  output logic [RAM_ADDR_W-1:0] RamAddress,
  output logic [DATA_W-1:0]     RamData,
  output logic                  RamWrite,
  input  logic                  RamReady,
  output logic                  RamRead,
  input  logic [DATA_W-1:0]     RamQ,
  input  logic                  RamQValid,
  output logic                  CpuHalt,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ROM_ADDR_W-1:0] ErrAddr
);

  // One extra index bit so a full 2^ROM_ADDR_W image never overflows.
  localparam int unsigned IDX_W    = ROM_ADDR_W + 1;
  localparam int unsigned LAST_IDX = (IMAGE_LEN == 0) ? 0 : IMAGE_LEN - 1;

  boot_state_t           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_data;
  logic                  r_halt;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_last;
  logic [RAM_ADDR_W-1:0] w_ram_addr;

`ifdef BOOT_VERIFY_EN
  logic                  r_error;
  logic [ROM_ADDR_W-1:0] r_err_addr;
`endif

  assign w_last     = (r_idx == IDX_W'(LAST_IDX));
  assign w_ram_addr = RAM_ADDR_W'(LOAD_BASE) + RAM_ADDR_W'(r_idx);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_halt  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef BOOT_VERIFY_EN
      r_error    <= 1'b0;
      r_err_addr <= '0;
`endif
    end else begin
      case (r_state)
        // A Start from any resting state restarts the whole load.
        S_IDLE, S_DONE, S_ERROR: begin
          if (Start) begin
            r_idx <= '0;
`ifdef BOOT_VERIFY_EN
            r_error <= 1'b0;
`endif
            if (IMAGE_LEN == 0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_halt  <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_FETCH;
              r_done  <= 1'b0;
              r_halt  <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_data  <= RomData;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (RamReady) begin
            if (!w_last) begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_FETCH;
            end else begin
`ifdef BOOT_VERIFY_EN
              r_idx   <= '0;
              r_state <= S_VREAD;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_halt  <= 1'b0;
              r_busy  <= 1'b0;
`endif
            end
          end
        end
`ifdef BOOT_VERIFY_EN
        // ROM answers combinationally, so RomData is the reference word for idx.
        S_VREAD: begin
          if (RamQValid) begin
            if (RamQ != RomData) begin
              r_err_addr <= r_idx[ROM_ADDR_W-1:0];
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_ERROR;
            end else if (!w_last) begin
              r_idx <= r_idx + IDX_W'(1);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_halt  <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RomAddress = r_idx[ROM_ADDR_W-1:0];
  assign RamWrite   = (r_state == S_WRITE);
  assign RamData    = RamWrite ? r_data : '0;
  assign RamAddress = (RamWrite || RamRead) ? w_ram_addr : '0;
  assign CpuHalt    = r_halt;
  assign Busy       = r_busy;
  assign Done       = r_done;

`ifdef BOOT_VERIFY_EN
  assign RamRead = (r_state == S_VREAD);
  assign Error   = r_error;
  assign ErrAddr = r_err_addr;
`else
  logic w_unused_q;
  assign w_unused_q = ^{RamQ, RamQValid};
  assign RamRead    = 1'b0;
  assign Error      = 1'b0;
  assign ErrAddr    = '0;
`endif

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Bench for boot_copy_ctrl: instance A (base 0x10, 8 words), B (base 0xFE, 4 words), C (empty image).
// Verify-path expectations follow BOOT_VERIFY_EN in the same way as the design build.
module tb_boot_copy_ctrl;

`ifdef BOOT_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int LEN_A = 8;
  localparam int LEN_B = 4;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] rom   [16];
  logic [3:0] a_ram [256];
  logic [3:0] b_ram [256];

  int a_wr_cnt, a_stalls, a_hold_cnt, a_stall_left;

  logic       a_start, a_ram_wr, a_ram_rdy, a_ram_rd, a_ram_qv, a_halt, a_busy, a_done, a_err;
  logic [3:0] a_rom_addr, a_rom_data, a_ram_data, a_ram_q, a_err_addr;
  logic [7:0] a_ram_addr;
  logic       b_start, b_ram_wr, b_ram_rdy, b_ram_rd, b_ram_qv, b_halt, b_busy, b_done, b_err;
  logic [3:0] b_rom_addr, b_rom_data, b_ram_data, b_ram_q, b_err_addr;
  logic [7:0] b_ram_addr;
  logic       c_start, c_ram_wr, c_ram_rdy, c_ram_rd, c_ram_qv, c_halt, c_busy, c_done, c_err;
  logic [3:0] c_rom_addr, c_rom_data, c_ram_data, c_ram_q, c_err_addr;
  logic [7:0] c_ram_addr;

  assign a_rom_data = rom[a_rom_addr];
  assign b_rom_data = rom[b_rom_addr];
  assign b_ram_rdy  = 1'b1;
  assign b_ram_qv   = b_ram_rd;
  assign b_ram_q    = b_ram[b_ram_addr];
  assign c_rom_data = 4'h0;
  assign c_ram_rdy  = 1'b1;
  assign c_ram_q    = 4'h0;
  assign c_ram_qv   = 1'b0;

  boot_copy_ctrl #(.ROM_ADDR_W(4), .DATA_W(4), .RAM_ADDR_W(8), .IMAGE_LEN(LEN_A), .LOAD_BASE(32'h10)) u_dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Start(a_start), .RomAddress(a_rom_addr), .RomData(a_rom_data),
    .RamAddress(a_ram_addr), .RamData(a_ram_data), .RamWrite(a_ram_wr), .RamReady(a_ram_rdy),
    .RamRead(a_ram_rd), .RamQ(a_ram_q), .RamQValid(a_ram_qv), .CpuHalt(a_halt), .Busy(a_busy),
    .Done(a_done), .Error(a_err), .ErrAddr(a_err_addr));

  boot_copy_ctrl #(.ROM_ADDR_W(4), .DATA_W(4), .RAM_ADDR_W(8), .IMAGE_LEN(LEN_B), .LOAD_BASE(32'hFE)) u_dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Start(b_start), .RomAddress(b_rom_addr), .RomData(b_rom_data),
    .RamAddress(b_ram_addr), .RamData(b_ram_data), .RamWrite(b_ram_wr), .RamReady(b_ram_rdy),
    .RamRead(b_ram_rd), .RamQ(b_ram_q), .RamQValid(b_ram_qv), .CpuHalt(b_halt), .Busy(b_busy),
    .Done(b_done), .Error(b_err), .ErrAddr(b_err_addr));

  boot_copy_ctrl #(.ROM_ADDR_W(4), .DATA_W(4), .RAM_ADDR_W(8), .IMAGE_LEN(0), .LOAD_BASE(32'h20)) u_dut_c (
    .Clk(Clk), .Rst_n(Rst_n), .Start(c_start), .RomAddress(c_rom_addr), .RomData(c_rom_data),
    .RamAddress(c_ram_addr), .RamData(c_ram_data), .RamWrite(c_ram_wr), .RamReady(c_ram_rdy),
    .RamRead(c_ram_rd), .RamQ(c_ram_q), .RamQValid(c_ram_qv), .CpuHalt(c_halt), .Busy(c_busy),
    .Done(c_done), .Error(c_err), .ErrAddr(c_err_addr));

  task automatic load_default();
    logic [31:0] img;
    img = 32'hEBA565A7;
    for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? img[4*(7-i) +: 4] : 4'h0;
  endtask

  // Fill target windows with the complement of the image so stale words never match.
  task automatic clear_rams();
    for (int j = 0; j < 256; j++) begin
      a_ram[j] = 4'h0;
      b_ram[j] = 4'h0;
    end
    for (int i = 0; i < LEN_A; i++) a_ram[8'(32'h10 + i)] = ~rom[i];
    for (int i = 0; i < LEN_B; i++) b_ram[8'(32'hFE + i)] = ~rom[i];
  endtask

  // One cycle of the IRAM/handshake model for A; mode 0 tied ready, 1 random, 2 stall at 0x12.
  task automatic step_a(input int mode, input int bad_idx);
    @(negedge Clk);
    a_start = 1'b0;
    if (mode == 1) a_ram_rdy = ($urandom_range(0, 2) != 0);
    else if (mode == 2 && a_ram_wr && a_ram_addr == 8'h12 && a_stall_left > 0) begin
      a_ram_rdy = 1'b0;
      a_stall_left--;
    end else a_ram_rdy = 1'b1;
    a_ram_qv = 1'b0;
    a_ram_q  = 4'h0;
    if (a_ram_rd) begin
      a_ram_qv = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_ram_q  = (int'(a_rom_addr) == bad_idx) ? 4'h0 : a_ram[a_ram_addr];
    end
    if (a_ram_wr && a_ram_addr == 8'h12 && a_ram_data == 4'ha) a_hold_cnt++;
    if (a_ram_wr && a_ram_rdy) begin
      a_ram[a_ram_addr] = a_ram_data;
      a_wr_cnt++;
    end
    if ((a_ram_wr && !a_ram_rdy) || (a_ram_rd && !a_ram_qv)) a_stalls++;
  endtask

  // Start pulse then run A until Done/Error; cyc is the first cycle it is seen, -1 on timeout.
  task automatic run_a(input int mode, input int bad_idx, output int cyc, output bit hb, output bit bb);
    a_wr_cnt = 0; a_stalls = 0; a_hold_cnt = 0; hb = 1'b0; bb = 1'b0; cyc = -1;
    @(negedge Clk);
    a_start = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      step_a(mode, bad_idx);
      if (a_halt !== !a_done) hb = 1'b1;
      if (a_busy !== !(a_done || a_err)) bb = 1'b1;
      if (a_done || a_err) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if ({a_halt, a_busy, a_done, a_err, a_ram_wr, a_ram_rd} !== 6'b100000) begin errors++;
      $display("FAIL reset_a_flags: got %b expected 100000", {a_halt, a_busy, a_done, a_err, a_ram_wr, a_ram_rd}); end
    checks++; if ({a_rom_addr, a_ram_addr, a_ram_data, a_err_addr} !== 20'h0) begin errors++;
      $display("FAIL reset_a_buses: got %h expected 0", {a_rom_addr, a_ram_addr, a_ram_data, a_err_addr}); end
    checks++; if ({b_halt, b_busy, b_done, b_err, b_ram_wr, b_ram_rd} !== 6'b100000) begin errors++;
      $display("FAIL reset_b_flags: got %b expected 100000", {b_halt, b_busy, b_done, b_err, b_ram_wr, b_ram_rd}); end
    checks++; if ({b_rom_addr, b_ram_addr, b_ram_data, b_err_addr} !== 20'h0) begin errors++;
      $display("FAIL reset_b_buses: got %h expected 0", {b_rom_addr, b_ram_addr, b_ram_data, b_err_addr}); end
    checks++; if ({c_halt, c_busy, c_done, c_err, c_ram_wr, c_ram_rd} !== 6'b100000) begin errors++;
      $display("FAIL reset_c_flags: got %b expected 100000", {c_halt, c_busy, c_done, c_err, c_ram_wr, c_ram_rd}); end
    checks++; if ({c_rom_addr, c_ram_addr, c_ram_data, c_err_addr} !== 20'h0) begin errors++;
      $display("FAIL reset_c_buses: got %h expected 0", {c_rom_addr, c_ram_addr, c_ram_data, c_err_addr}); end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_default_image();
    int cyc; bit hb, bb;
    load_default(); clear_rams();
    run_a(0, -1, cyc, hb, bb);
    checks++; if (cyc != 1 + 2*LEN_A + VER*LEN_A) begin errors++;
      $display("FAIL default_done_cycle: got %0d expected %0d", cyc, 1 + 2*LEN_A + VER*LEN_A); end
    checks++; if (hb || bb) begin errors++;
      $display("FAIL default_halt_busy_track: got halt_bad=%0d busy_bad=%0d expected 0 0", hb, bb); end
    checks++; if ({a_done, a_err, a_halt, a_busy} !== 4'b1000) begin errors++;
      $display("FAIL default_final_flags: got %b expected 1000", {a_done, a_err, a_halt, a_busy}); end
    checks++; if (a_wr_cnt != LEN_A) begin errors++;
      $display("FAIL default_write_count: got %0d expected %0d", a_wr_cnt, LEN_A); end
    for (int i = 0; i < LEN_A; i++) begin
      checks++; if (a_ram[8'(32'h10 + i)] !== rom[i]) begin errors++;
        $display("FAIL default_iram[%0d]: got %h expected %h", i, a_ram[8'(32'h10 + i)], rom[i]); end
    end
  endtask

  task automatic test_stall();
    int cyc; bit hb, bb;
    load_default(); clear_rams();
    a_stall_left = 3;
    run_a(2, -1, cyc, hb, bb);
    checks++; if (a_hold_cnt != 4) begin errors++;
      $display("FAIL stall_hold_cycles: got %0d expected 4", a_hold_cnt); end
    checks++; if (a_wr_cnt != LEN_A) begin errors++;
      $display("FAIL stall_write_count: got %0d expected %0d", a_wr_cnt, LEN_A); end
    checks++; if (cyc != 1 + 2*LEN_A + VER*LEN_A + 3) begin errors++;
      $display("FAIL stall_done_cycle: got %0d expected %0d", cyc, 1 + 2*LEN_A + VER*LEN_A + 3); end
    for (int i = 0; i < LEN_A; i++) begin
      checks++; if (a_ram[8'(32'h10 + i)] !== rom[i]) begin errors++;
        $display("FAIL stall_iram[%0d]: got %h expected %h", i, a_ram[8'(32'h10 + i)], rom[i]); end
    end
  endtask

  task automatic test_verify_error();
    int cyc; bit hb, bb;
    load_default(); clear_rams();
    run_a(0, 5, cyc, hb, bb);
`ifdef BOOT_VERIFY_EN
    checks++; if ({a_err, a_done, a_halt} !== 3'b101) begin errors++;
      $display("FAIL verr_flags: got err,done,halt=%b expected 101", {a_err, a_done, a_halt}); end
    checks++; if (a_err_addr !== 4'd5) begin errors++;
      $display("FAIL verr_addr: got %0d expected 5", a_err_addr); end
    checks++; if (cyc != 1 + 2*LEN_A + 6) begin errors++;
      $display("FAIL verr_cycle: got %0d expected %0d", cyc, 1 + 2*LEN_A + 6); end
`else
    checks++; if ({a_err, a_done, a_halt} !== 3'b010) begin errors++;
      $display("FAIL noverify_flags: got err,done,halt=%b expected 010", {a_err, a_done, a_halt}); end
    checks++; if (a_err_addr !== 4'd0) begin errors++;
      $display("FAIL noverify_erraddr: got %0d expected 0", a_err_addr); end
`endif
    checks++; if (hb) begin errors++;
      $display("FAIL verr_halt_track: got halt_bad=1 expected 0"); end
  endtask

  task automatic test_random();
    int cyc; bit hb, bb;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
      clear_rams();
      run_a(1, -1, cyc, hb, bb);
      checks++; if (cyc != 1 + 2*LEN_A + VER*LEN_A + a_stalls) begin errors++;
        $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, cyc, 1 + 2*LEN_A + VER*LEN_A + a_stalls); end
      checks++; if (a_wr_cnt != LEN_A || hb || bb) begin errors++;
        $display("FAIL rand%0d_writes_track: got wr=%0d hb=%0d bb=%0d expected %0d 0 0", it, a_wr_cnt, hb, bb, LEN_A); end
      for (int i = 0; i < LEN_A; i++) begin
        checks++; if (a_ram[8'(32'h10 + i)] !== rom[i]) begin errors++;
          $display("FAIL rand%0d_iram[%0d]: got %h expected %h", it, i, a_ram[8'(32'h10 + i)], rom[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] addrs [$];
    logic [3:0] datas [$];
    logic [7:0] ea;
    int cyc;
    load_default(); clear_rams();
    cyc = -1;
    @(negedge Clk);
    b_start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge Clk);
      b_start = 1'b0;
      if (b_ram_wr) begin
        b_ram[b_ram_addr] = b_ram_data;
        addrs.push_back(b_ram_addr);
        datas.push_back(b_ram_data);
      end
      if (b_done || b_err) begin
        cyc = n;
        break;
      end
    end
    checks++; if (addrs.size() != LEN_B) begin errors++;
      $display("FAIL wrap_write_count: got %0d expected %0d", addrs.size(), LEN_B); end
    for (int i = 0; i < LEN_B && i < addrs.size(); i++) begin
      ea = 8'(32'hFE + i);
      checks++; if (addrs[i] !== ea || datas[i] !== rom[i]) begin errors++;
        $display("FAIL wrap_write[%0d]: got %h/%h expected %h/%h", i, addrs[i], datas[i], ea, rom[i]); end
    end
    checks++; if (cyc != 1 + 2*LEN_B + VER*LEN_B || b_done !== 1'b1) begin errors++;
      $display("FAIL wrap_done: got cycle %0d done %b expected %0d 1", cyc, b_done, 1 + 2*LEN_B + VER*LEN_B); end
  endtask

  task automatic test_zero();
    @(negedge Clk);
    checks++; if (c_done !== 1'b0) begin errors++;
      $display("FAIL zero_pre_done: got %b expected 0", c_done); end
    c_start = 1'b1;
    @(negedge Clk);
    c_start = 1'b0;
    checks++; if ({c_done, c_halt, c_busy, c_ram_wr, c_ram_rd} !== 5'b10000) begin errors++;
      $display("FAIL zero_done_next: got %b expected 10000", {c_done, c_halt, c_busy, c_ram_wr, c_ram_rd}); end
    c_start = 1'b1;
    @(negedge Clk);
    c_start = 1'b0;
    checks++; if ({c_done, c_halt} !== 2'b10) begin errors++;
      $display("FAIL zero_restart: got done,halt=%b expected 10", {c_done, c_halt}); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit hb, bb;
    load_default(); clear_rams();
    a_wr_cnt = 0;
    @(negedge Clk);
    a_start = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step_a(0, -1);
      if (a_wr_cnt == 3) break;
    end
    step_a(0, -1);
    checks++; if (a_rom_addr !== 4'd3 || a_busy !== 1'b1) begin errors++;
      $display("FAIL mid_at_word3: got rom_addr %0d busy %b expected 3 1", a_rom_addr, a_busy); end
    Rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step_a(0, -1);
      checks++; if ({a_halt, a_busy, a_done, a_err, a_ram_wr, a_ram_rd} !== 6'b100000 ||
                    {a_rom_addr, a_ram_addr, a_ram_data, a_err_addr} !== 20'h0) begin errors++;
        $display("FAIL mid_reset_values[%0d]: got %b %h expected 100000 0", k,
                 {a_halt, a_busy, a_done, a_err, a_ram_wr, a_ram_rd}, {a_rom_addr, a_ram_addr, a_ram_data, a_err_addr}); end
    end
    Rst_n = 1'b1;
    clear_rams();
    run_a(0, -1, cyc, hb, bb);
    checks++; if (cyc != 1 + 2*LEN_A + VER*LEN_A || a_wr_cnt != LEN_A) begin errors++;
      $display("FAIL mid_reload: got cycle %0d writes %0d expected %0d %0d", cyc, a_wr_cnt, 1 + 2*LEN_A + VER*LEN_A, LEN_A); end
    for (int i = 0; i < LEN_A; i++) begin
      checks++; if (a_ram[8'(32'h10 + i)] !== rom[i]) begin errors++;
        $display("FAIL mid_iram[%0d]: got %h expected %h", i, a_ram[8'(32'h10 + i)], rom[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit hb, bb;
    load_default(); clear_rams();
    run_a(0, -1, cyc, hb, bb);
    checks++; if (a_done !== 1'b1) begin errors++;
      $display("FAIL b2b_first_done: got %b expected 1", a_done); end
    clear_rams();
    a_wr_cnt = 0;
    cyc = -1;
    @(negedge Clk);
    a_start = 1'b1;
    step_a(0, -1);
    checks++; if ({a_done, a_busy, a_halt} !== 3'b011) begin errors++;
      $display("FAIL b2b_restart_flags: got done,busy,halt=%b expected 011", {a_done, a_busy, a_halt}); end
    for (int n = 2; n <= 200; n++) begin
      step_a(0, -1);
      if (n == 3) a_start = 1'b1;
      if (a_done || a_err) begin
        cyc = n;
        break;
      end
    end
    checks++; if (cyc != 1 + 2*LEN_A + VER*LEN_A) begin errors++;
      $display("FAIL b2b_done_cycle: got %0d expected %0d", cyc, 1 + 2*LEN_A + VER*LEN_A); end
    checks++; if (a_wr_cnt != LEN_A || a_ram[8'h17] !== rom[7]) begin errors++;
      $display("FAIL b2b_reload: got writes %0d last %h expected %0d %h", a_wr_cnt, a_ram[8'h17], LEN_A, rom[7]); end
  endtask

  initial begin
    Rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_ram_rdy = 1'b1; a_ram_qv = 1'b0; a_ram_q = 4'h0;
    a_wr_cnt = 0; a_stalls = 0; a_hold_cnt = 0; a_stall_left = 0;
    load_default();
    clear_rams();
    test_reset();
    test_default_image();
    test_stall();
    test_verify_error();
    test_random();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_copy_ctrl.md
# boot_copy_ctrl

Boot sequencer that copies the bootloader program image from the combinational bootloader ROM into instruction RAM after reset, then releases the CPU. It sits between the bootloader ROM, the IRAM write/read port and the CPU halt input. It walks ROM addresses, writes each 4-bit opcode into IRAM through a ready/valid handshake and optionally reads it back for verification. It reports `Busy`, `Done` or `Error`.

## Interface
- `ROM_ADDR_W`, 4: bootloader ROM address width
- `DATA_W`, 4: opcode width
- `RAM_ADDR_W`, 8: IRAM address width
- `IMAGE_LEN`, 8: words to copy, 0..2^ROM_ADDR_W
- `LOAD_BASE`, 0: first IRAM address written
- `Clk`  in  1  system clock
- `Rst_n`  in  1  synchronous, active-low reset; single clock domain
- `Start`  in  1  one-cycle request to (re)load
- `RomAddress`  out  ROM_ADDR_W  ROM address; ROM data returns combinationally in the same cycle
- `RomData`  in  DATA_W  ROM opcode
- `RamAddress`  out  RAM_ADDR_W  IRAM address
- `RamData`  out  DATA_W  IRAM write data
- `RamWrite`  out  1  write request, held until `RamReady`
- `RamReady`  in  1  write accepted this cycle
- `RamRead`  out  1  read request, held until `RamQValid` (verify only)
- `RamQ`  in  DATA_W  IRAM read data
- `RamQValid`  in  1  `RamQ` valid this cycle
- `CpuHalt`  out  1  holds the CPU while high
- `Busy`  out  1  copy or verify in progress
- `Done`  out  1  sticky: image loaded and verified
- `Error`  out  1  sticky: verify mismatch
- `ErrAddr`  out  ROM_ADDR_W  index of the first mismatching word

## Operation
- States: IDLE, FETCH, WRITE, VREAD, DONE, ERROR.
- IDLE:
  - `Start` with IMAGE_LEN=0 → DONE.
  - `Start` with IMAGE_LEN>0 → FETCH, with idx cleared to 0.
- FETCH:
  - Drive `RomAddress`=idx.
  - Latch `RomData` into the data register.
  - → WRITE.
- WRITE:
  - Drive `RamWrite`=1, `RamAddress`=LOAD_BASE+idx (truncated to RAM_ADDR_W, wraps modulo 2^RAM_ADDR_W), `RamData`=latched word.
  - On `RamReady`, when idx<IMAGE_LEN-1: idx++ and → FETCH.
  - On `RamReady`, when idx=IMAGE_LEN-1: → VREAD with idx=0 (verify built) or → DONE.
  - Outputs are stable while `RamReady`=0.
- VREAD:
  - Drive `RamRead`=1, `RamAddress`=LOAD_BASE+idx, `RomAddress`=idx.
  - On `RamQValid`, when `RamQ`==`RomData`: advance as in WRITE; after the last word → DONE.
  - On `RamQValid` with a mismatch: `ErrAddr`=idx and → ERROR.
- DONE: `Done`=1, `CpuHalt`=0.
- ERROR: `Error`=1, `CpuHalt` stays 1.
- `Start` in DONE or ERROR clears `Done`/`Error`, sets `CpuHalt`=1 and restarts the load as from IDLE.
- `Start` in FETCH, WRITE or VREAD is ignored.
- idx is ROM_ADDR_W+1 bits wide, so IMAGE_LEN=2^ROM_ADDR_W does not overflow. `RomAddress` is idx[ROM_ADDR_W-1:0].
- `RamWrite` and `RamRead` are never high in the same cycle.

## Timing
- Reset values:
  - State IDLE, idx 0.
  - `CpuHalt`=1.
  - `Busy`, `Done`, `Error`, `RamWrite`, `RamRead`=0.
  - `RomAddress`, `RamAddress`, `RamData`, `ErrAddr`=0.
- Reset asserted mid-load aborts immediately to the reset values. The partial IRAM content is left as is.
- `Busy`=1 in FETCH, WRITE and VREAD; it is registered and rises the cycle after `Start`.
- Each word takes a minimum of 2 cycles to copy (FETCH + WRITE with `RamReady`=1), plus 1 cycle per word to verify when `RamQValid` is immediate.
- IMAGE_LEN=8 with ready tied high: `Done` rises 17 cycles after `Start` without verify and 25 cycles with verify.
- IMAGE_LEN=0: `Done` rises 1 cycle after `Start`.
- All outputs are registered except `RamAddress`, `RomAddress`, `RamData`, `RamWrite` and `RamRead`, which decode from state and idx.

## Configuration
- `BOOT_VERIFY_EN`
  - Defined: the VREAD state and the compare logic are built.
  - Undefined: VREAD is absent, WRITE of the last word goes straight to DONE, `RamRead` and `Error` are tied 0, `ErrAddr` is tied 0, and `RamQ`/`RamQValid` are unused.

## Structure
- Package `boot_pkg`:
  - State enum `boot_state_t`.
  - Opcode width constant.
  - The default image length.
- No sub-module.
  - The bootloader ROM stays outside the block, so program images can be swapped without touching the controller.

## Test plan
- Default ROM image e,b,a,5,6,5,a,7, LOAD_BASE=0x10, ready tied 1, `Start` pulse → IRAM 0x10..0x17 holds e,b,a,5,6,5,a,7, `Done` at cycle 25, `CpuHalt` falls with `Done`.
- `RamReady` low for 3 cycles on word 2 → `RamAddress`=0x12 and `RamData`=a are held for 4 cycles, no duplicate write, final content unchanged.
- Verify with `RamQ` forced to 0 at word 5 → `Error`=1, `ErrAddr`=5, `CpuHalt` stays 1, `Done`=0.
- LOAD_BASE=0xFE, IMAGE_LEN=4 → writes land at 0xFE, 0xFF, 0x00, 0x01.
- `Rst_n` low at word 3, then a new `Start` → all outputs at reset values during reset, then a full clean reload.
- `Start` while `Busy` ignored; `Start` after `Done` → `Done` clears next cycle, reload completes, `Done` returns.
